// File: rtl/mem_lsu.sv
// MEM pipeline stage with integrated load/store unit: single-cycle pass-through for ALU ops,
// req/ack data-memory transactions with big-endian lane steering, extension and bus timeout.
module mem_lsu #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            memop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  stall_req_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] SzNone = 2'd0;
  localparam logic [1:0] SzByte = 2'd1;
  localparam logic [1:0] SzHalf = 2'd2;
  localparam logic [1:0] SzWord = 2'd3;

  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  valid_q, valid_d, wreg_q, wreg_d, misalign_q, misalign_d;
  logic                  bus_err_q, bus_err_d, req_q, req_d, we_q, we_d, lwreg_q, lwreg_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d, lwd_q, lwd_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, mwdata_q, mwdata_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [3:0]            sel_q, sel_d, op_q, op_d;
  logic [1:0]            off_q, off_d;

  logic [1:0]            size;
  logic                  is_store, misalign;
  logic [3:0]            sel_c;
  logic [DATA_W-1:0]     wdata_c, ld_val;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  timeout_hit;

  // Request formation from the incoming EX/MEM fields.
  always_comb begin
    size     = SzNone;
    is_store = 1'b0;
    unique case (memop_i)
      4'd1, 4'd2: size = SzByte;
      4'd3, 4'd4: size = SzHalf;
      4'd5:       size = SzWord;
      4'd6: begin size = SzByte; is_store = 1'b1; end
      4'd7: begin size = SzHalf; is_store = 1'b1; end
      4'd8: begin size = SzWord; is_store = 1'b1; end
      default: size = SzNone;
    endcase
    misalign = ((size == SzHalf) && mem_addr_i[0]) ||
               ((size == SzWord) && (mem_addr_i[1:0] != 2'b00));
    sel_c    = 4'b1111;
    wdata_c  = store_data_i;
    if (size == SzByte) begin
      sel_c   = 4'b1000 >> mem_addr_i[1:0];
      wdata_c = {4{store_data_i[7:0]}};
    end else if (size == SzHalf) begin
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{store_data_i[15:0]}};
    end
  end

  // Big-endian lane extraction: offset 0 lives in bits 31:24.
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = mem_rdata_i[31:24];
      2'd1:    ld_byte = mem_rdata_i[23:16];
      2'd2:    ld_byte = mem_rdata_i[15:8];
      default: ld_byte = mem_rdata_i[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    unique case (op_q)
      4'd1:    ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      4'd2:    ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
      4'd3:    ld_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      4'd4:    ld_val = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_val = mem_rdata_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    wd_d       = '0;
    wreg_d     = 1'b0;
    wdata_d    = '0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    mwdata_d   = mwdata_q;
    op_d       = op_q;
    off_d      = off_q;
    lwd_d      = lwd_q;
    lwreg_d    = lwreg_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (size == SzNone) begin
            valid_d = 1'b1;
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
          end else if (misalign) begin
            valid_d    = 1'b1;
            wd_d       = wd_i;
            misalign_d = 1'b1;
          end else begin
            state_d  = StAccess;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = is_store;
            addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
            sel_d    = sel_c;
            mwdata_d = wdata_c;
            op_d     = memop_i;
            off_d    = mem_addr_i[1:0];
            lwd_d    = wd_i;
            lwreg_d  = wreg_i;
          end
        end
      end
      default: begin
        if (mem_ack_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          req_d   = 1'b0;
          valid_d = 1'b1;
          wd_d    = lwd_q;
          wreg_d  = we_q ? 1'b0 : lwreg_q;
          wdata_d = we_q ? '0 : ld_val;
        end else if (timeout_hit) begin
          state_d   = StIdle;
          cnt_d     = '0;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          wd_d      = lwd_q;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      mwdata_q   <= '0;
      op_q       <= '0;
      off_q      <= '0;
      lwd_q      <= '0;
      lwreg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      mwdata_q   <= mwdata_d;
      op_q       <= op_d;
      off_q      <= off_d;
      lwd_q      <= lwd_d;
      lwreg_q    <= lwreg_d;
    end
  end

  assign stall_req_o = (state_q == StAccess);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_sel_o   = sel_q;
  assign mem_wdata_o = mwdata_q;
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Registered MEM pipeline stage with integrated load/store unit; sits between EX/MEM and MEM/WB.
- Non-memory ops pass through with 1-cycle latency; loads/stores run a request/acknowledge transaction to data memory with upstream stall, byte-lane steering, sign/zero extension, misalignment detection and bus timeout.

Parameters:
- DATA_W, 32, data/register width; byte lanes = DATA_W/8, and DATA_W must be 32.
- ADDR_W, 32, memory address width.
- REG_ADDR_W, 5, destination register address width.
- TIMEOUT, 16, cycles without ack before abort; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX result valid this cycle.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  DATA_W  ALU result.
- memop_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- mem_addr_i  in  ADDR_W  effective address.
- store_data_i  in  DATA_W  store data (low bits used).
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits zero).
- mem_sel_o  out  4  byte enables; bit 3 = bits 31:24.
- mem_wdata_o  out  DATA_W  lane-replicated store data.
- mem_ack_i  in  1  memory done; rdata valid same cycle.
- mem_rdata_i  in  DATA_W  load word.
- stall_req_o  out  1  hold upstream stages.
- valid_o  out  1  result valid (1-cycle pulse per instruction).
- wd_o  out  REG_ADDR_W  destination register.
- wreg_o  out  1  write enable; forced 0 whenever valid_o=0.
- wdata_o  out  DATA_W  writeback data.
- misalign_o  out  1  pulses with valid_o on misaligned access.
- bus_err_o  out  1  pulses with valid_o on timeout.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0. Reset mid-ACCESS drops mem_req_o immediately, and no result is produced.
- Big-endian lanes: address offset 0 is bits 31:24, offset 3 is bits 7:0.
- States: IDLE, ACCESS.
- IDLE with valid_i=0: next cycle valid_o=0, wreg_o=0.
- IDLE, valid_i=1, memop none: next cycle valid_o=1, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i.
- IDLE, valid_i=1, memop misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0): no request issued. Next cycle valid_o=1, misalign_o=1, wreg_o=0.
- IDLE, valid_i=1, aligned mem op:
  - Latch wd, wreg, op, and offset.
  - Next cycle: state ACCESS; mem_req_o=1 with registered addr/we/sel/wdata.
- ACCESS:
  - stall_req_o=1, including the ack cycle. valid_i is ignored.
  - mem_req_o and all request fields are held stable until the ack cycle.
  - The counter increments each cycle without ack.
- On ack:
  - Next cycle: valid_o=1, mem_req_o=0, state IDLE, counter cleared.
  - Loads: wreg_o=latched wreg; wdata_o=selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU), or the full word (LW).
  - Stores: wreg_o=0; wdata_o=0.
- Timeout: when TIMEOUT>0 and the counter reaches TIMEOUT with no ack, abort. Next cycle: mem_req_o=0, valid_o=1, bus_err_o=1, wreg_o=0, state IDLE.
- Ack arriving in the same cycle as the timeout threshold: ack wins.
- Store steering:
  - SB: wdata = byte replicated to all 4 lanes; sel = one-hot per offset (offset 0 gives 1000).
  - SH: wdata = halfword replicated; sel = 1100 (offset 0) or 0011 (offset 2).
  - SW: wdata = store_data_i; sel = 1111.
- Loads drive sel identically to stores of the same size.
- mem_ack_i while not in ACCESS is ignored.
- Stall latency: a memory op occupies the stage for at least 3 cycles (accept, ACCESS with ack, result). Back-to-back non-memory ops run at 1 per cycle.

Test Plan:
- Reset mid-op: drive rst=0 in ACCESS before ack → mem_req_o=0, stall_req_o=0 and valid_o=0 immediately. After release, IDLE; a following ALU op completes normally.
- Pass-through: valid_i=1, memop=0, wd_i=5, wreg_i=1, wdata_i=0x12345678 → next cycle valid_o=1, wd_o=5, wreg_o=1, wdata_o=0x12345678, stall_req_o=0.
- LB: addr 0x00000103, wd_i=8; ack after 2 wait cycles with rdata 0x112233F0:
  - During the request: mem_addr_o=0x00000100, sel=0001, stall_req_o=1.
  - Result: wdata_o=0xFFFFFFF0, wd_o=8, wreg_o=1.
- LHU: addr offset 2, rdata 0xAABB8001, immediate ack → wdata_o=0x00008001. SB: offset 1, store_data_i=0x000000A5 → sel=0100, mem_wdata_o=0xA5A5A5A5, mem_we_o=1, result wreg_o=0.
- Misaligned LW: addr 0x00000102 → mem_req_o never asserted; next cycle valid_o=1, misalign_o=1, wreg_o=0.
- Timeout: TIMEOUT=4, LW with no ack → mem_req_o held 4 cycles then dropped; valid_o=1, bus_err_o=1, wreg_o=0. Repeat with ack on the 4th cycle → normal load result, bus_err_o=0.
